// File: rtl/branch_resolve_bht_pkg.sv
// Shared types and helpers for the branch resolution unit and its bimodal history table.
package branch_resolve_bht_pkg;

    typedef enum logic [2:0] {
        BR_NOP  = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6,
        BR_RSVD = 3'd7
    } br_op_e;

    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] ST  = 2'b11;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] sat2_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == ST) ? ST : (cnt + 2'd1);
        end else begin
            nxt = (cnt == 2'b00) ? 2'b00 : (cnt - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_bht_table.sv
// Bimodal history table: one combinational read port, one saturating-update write port.
module bht_table
    import branch_resolve_bht_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_cnt,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    logic [1:0] mem_q [DEPTH];

    // Reads see the stored value, so a same-cycle update is only visible next cycle.
    assign o_rd_cnt = mem_q[i_rd_idx];

    // Counter storage with async reset to weakly not-taken.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WNT;
            end
        end else if (i_we) begin
            mem_q[i_wr_idx] <= sat2_update(mem_q[i_wr_idx], i_wr_taken);
        end else begin
            mem_q[i_wr_idx] <= mem_q[i_wr_idx];
        end
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch resolution unit: BHT prediction, compare, registered redirect, flush window and stats.
module branch_resolve_bht
    import branch_resolve_bht_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_DEPTH    = 64,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [XLEN-1:0]  i_fetch_pc,
    output logic             o_pred_taken,
    input  logic             i_valid,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_rs2,
    input  logic [2:0]       i_br_op,
    input  logic             i_pred_taken,
    output logic             o_redirect,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_flush,
    output logic [CNT_W-1:0] o_mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);

    logic [IDX_W-1:0] rd_idx_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [1:0]       rd_cnt_s;
    logic             is_branch_s;
    logic             active_s;
    logic             taken_s;
    logic             mispredict_s;
    logic [XLEN-1:0]  target_s;
    logic [XLEN-1:0]  fallthrough_s;
    logic             unused_s;

    logic             redirect_q,    redirect_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [FL_W-1:0]  flush_cnt_q,   flush_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q,     mis_cnt_d;

    assign rd_idx_s = i_fetch_pc[IDX_W+1:2];
    assign wr_idx_s = i_pc[IDX_W+1:2];
    assign unused_s = ^{i_fetch_pc[XLEN-1:IDX_W+2], i_fetch_pc[1:0], rd_cnt_s[0]};

    bht_table #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rd_idx   (rd_idx_s),
        .o_rd_cnt   (rd_cnt_s),
        .i_we       (active_s),
        .i_wr_idx   (wr_idx_s),
        .i_wr_taken (taken_s)
    );

    assign o_pred_taken = rd_cnt_s[1];
    assign o_flush      = (flush_cnt_q != {FL_W{1'b0}});

    // Branch condition evaluation and mispredict detection.
    always_comb begin
        is_branch_s = 1'b1;
        taken_s     = 1'b0;
        case (br_op_e'(i_br_op))
            BR_BEQ:  taken_s = (i_rs1 == i_rs2);
            BR_BNE:  taken_s = (i_rs1 != i_rs2);
            BR_BLT:  taken_s = ($signed(i_rs1) <  $signed(i_rs2));
            BR_BGE:  taken_s = ($signed(i_rs1) >= $signed(i_rs2));
            BR_BLTU: taken_s = (i_rs1 <  i_rs2);
            BR_BGEU: taken_s = (i_rs1 >= i_rs2);
            default: is_branch_s = 1'b0;
        endcase
        active_s      = i_valid && !o_flush && is_branch_s;
        mispredict_s  = active_s && (taken_s != i_pred_taken);
        target_s      = i_pc + i_imm;
        fallthrough_s = i_pc + 32'(4);
    end

    // Next-state for redirect, flush window and mispredict statistics.
    always_comb begin
        redirect_d    = mispredict_s;
        redirect_pc_d = redirect_pc_q;
        flush_cnt_d   = flush_cnt_q;
        mis_cnt_d     = mis_cnt_q;
        if (mispredict_s) begin
            redirect_pc_d = taken_s ? target_s : fallthrough_s;
            flush_cnt_d   = FL_W'(FLUSH_CYCLES);
            mis_cnt_d     = (mis_cnt_q == {CNT_W{1'b1}}) ? mis_cnt_q : (mis_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1});
        end else if (o_flush) begin
            flush_cnt_d = flush_cnt_q - {{(FL_W-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_d = {FL_W{1'b0}};
        end
    end

    // Output and counter registers; async reset drops flush and redirect immediately.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= {XLEN{1'b0}};
            flush_cnt_q   <= {FL_W{1'b0}};
            mis_cnt_q     <= {CNT_W{1'b0}};
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            flush_cnt_q   <= flush_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    assign o_redirect       = redirect_q;
    assign o_redirect_pc    = redirect_pc_q;
    assign o_mispredict_cnt = mis_cnt_q;

endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- Parametrised branch resolution unit with a bimodal branch history table (BHT) of 2-bit saturating counters.
- Fetch side: looks up a taken/not-taken prediction by PC.
- Execute side: resolves conditional branches with correct signed and unsigned compares, then updates the BHT.
- On a misprediction it issues a registered redirect plus a multi-cycle flush, and it keeps a saturating mispredict counter.
- Sits between decode/execute and the fetch PC mux.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_DEPTH, 64, number of BHT entries; power of 2, minimum 2.
- FLUSH_CYCLES, 1, cycles o_flush stays high after a mispredict; minimum 1.
- CNT_W, 16, width of the mispredict statistics counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_fetch_pc  in  XLEN  PC being fetched (lookup address).
- o_pred_taken  out  1  prediction for i_fetch_pc; combinational.
- i_valid  in  1  branch present in the resolve stage this cycle.
- i_pc  in  XLEN  PC of the resolving branch.
- i_imm  in  XLEN  sign-extended branch offset.
- i_rs1  in  XLEN  operand 1.
- i_rs2  in  XLEN  operand 2.
- i_br_op  in  3  0 NOP, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 reserved.
- i_pred_taken  in  1  prediction that fetch made for this branch, carried down the pipe.
- o_redirect  out  1  one-cycle pulse: fetch must load o_redirect_pc.
- o_redirect_pc  out  XLEN  corrected next PC.
- o_flush  out  1  squash younger instructions.
- o_mispredict_cnt  out  CNT_W  saturating count of mispredicts.

Behaviour:
- Reset (async, i_rst=0):
  - Every BHT entry = 2'b01 (weakly not-taken).
  - o_redirect=0, o_redirect_pc=0, o_flush=0, flush counter=0, o_mispredict_cnt=0.
- Indexing:
  - IDX_W = $clog2(BHT_DEPTH).
  - idx = pc[IDX_W+1:2] for both the lookup and the update.
- Prediction: o_pred_taken = BHT[idx(i_fetch_pc)][1].
- Resolve, combinational:
  - Active when i_valid=1, o_flush=0, and i_br_op is in 1..6.
  - BLT/BGE use a signed compare.
  - BLTU/BGEU use an unsigned compare.
  - Ops 0 and 7 are not branches: no update, no redirect.
- Arithmetic:
  - target = i_pc + i_imm, truncated to XLEN (wraps).
  - fallthrough = i_pc + 4, truncated to XLEN (wraps).
- Mispredict = resolved taken != i_pred_taken.
- Registered outputs, latency 1: for a mispredict resolved in cycle N:
  - In cycle N+1, o_redirect=1 for exactly one cycle.
  - o_redirect_pc = target if taken, else fallthrough.
  - o_redirect_pc holds its value until the next redirect.
- Flush:
  - o_flush is high from N+1 through N+FLUSH_CYCLES, driven by a down-counter.
  - While o_flush=1, i_valid is ignored: no BHT update, no redirect, no count.
- BHT update:
  - Applied at the clock edge ending cycle N for every active resolve, predicted correctly or not.
  - Taken: counter increments, saturating at 3. Not taken: counter decrements, saturating at 0.
- Same-cycle lookup/update hazard: a lookup and an update to the same index in one cycle return the old (pre-update) value.
- Statistics: o_mispredict_cnt increments once per mispredict and saturates at all-ones.
- Mid-operation reset: an asynchronous reset during a flush clears o_flush and o_redirect immediately.

Decomposition:
- Shared package gets:
  - the br_op_e enum (BR_NOP..BR_BGEU, with 7 reserved);
  - the counter localparams WNT=2'b01 and ST=2'b11;
  - the function sat2_update(cnt, taken).
- One sub-module is natural: bht_table (parametrised, async-reset, one combinational read port, one write port, read-before-write).
- Compare, redirect and flush logic stay in the top module.

Test Plan:
- Reset with no activity -> o_pred_taken=0 for every PC; all outputs 0; o_mispredict_cnt=0.
- BLT, rs1=32'hFFFF_FFFF (-1), rs2=1, pc=0x100, imm=0x20, pred=0 -> next cycle:
  - o_redirect=1, o_redirect_pc=0x120;
  - o_flush high for FLUSH_CYCLES;
  - count=1.
- BLTU with the same operands -> not taken, pred=0 -> no redirect. BGEU with the same operands, pred=0 -> taken, redirect to 0x120.
- Repeated taken BEQ at pc=0x40, pred matching the BHT each time -> counter for idx 16 steps 01→10→11→11. o_pred_taken for 0x40 becomes 1 after the first update; no redirects after the first mispredict.
- BNE not-taken with pc=32'hFFFF_FFFC, pred=1 -> o_redirect_pc=0x0 (wrap). A valid branch during the following o_flush window -> ignored: no BHT change, no count.
- Force CNT_W=2 with 5 mispredicts -> o_mispredict_cnt saturates at 3. Assert i_rst mid-flush -> o_flush drops at once and the BHT returns to 01.
